// File: rtl/mem_access_unit.sv
// Byte-serial load/store engine between a pipeline MEM stage and an 8-bit data memory.
// Latency: 2N+1 cycles from the accepting edge to Done (N = 1/2/4 bytes); 1 cycle for a rejected misaligned access.
// Backpressure: Req is only accepted in IDLE; Req while Busy or in DONE is ignored.
// Optional alignment checking is enabled by defining MEM_ACCESS_MISALIGN_CHECK_EN.
`timescale 1ns/1ps

module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Write,
    input  logic [1:0]        Size,
    input  logic              Signed,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WData,
    output logic [31:0]       RData,
    output logic              Busy,
    output logic              Done,
    output logic              MisalignErr,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [7:0]        MemDataOut,
    input  logic [7:0]        MemDataIn
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [2:0]          cnt_q;        // bytes completed in the current access
    logic [2:0]          nbytes_q;     // bytes to transfer: 1, 2 or 4
    logic                write_q;
    logic                signed_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rbuf_q;       // load bytes shifted in, b0 ends up most significant
    logic [31:0]         rdata_q;
    logic                busy_q;
    logic                done_q;
    logic                misalign_q;
    logic                mem_en_q;
    logic                mem_rw_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [7:0]          mem_dout_q;

    // Combinational helpers feeding the FSM
    logic [2:0]          req_nbytes_d;
    logic                req_misalign_d;
    logic [7:0]          first_byte_d;
    logic [7:0]          next_byte_d;
    logic [31:0]         load_result_d;

    // Big-endian byte pick: byte k of an n-byte operand is the k-th most significant of its low n bytes.
    function automatic logic [7:0] sel_byte(input logic [31:0] d,
                                            input logic [2:0]  n,
                                            input logic [2:0]  k);
        logic [2:0] i;
        i = n - k - 3'd1;
        case (i)
            3'd0:    sel_byte = d[7:0];
            3'd1:    sel_byte = d[15:8];
            3'd2:    sel_byte = d[23:16];
            3'd3:    sel_byte = d[31:24];
            default: sel_byte = d[7:0];
        endcase
    endfunction

    // Operand length from Size; the reserved encoding behaves as a word.
    always_comb begin
        req_nbytes_d = 3'd4;
        case (Size)
            2'b00:   req_nbytes_d = 3'd1;
            2'b01:   req_nbytes_d = 3'd2;
            default: req_nbytes_d = 3'd4;
        endcase
    end

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    // Half accesses need an even address, word accesses a multiple of four.
    always_comb begin
        req_misalign_d = 1'b0;
        if (Size == 2'b01)
            req_misalign_d = Addr[0];
        else if (Size[1])
            req_misalign_d = (Addr[1:0] != 2'b00);
    end
`else
    // Without the check every alignment is legal; addresses simply wrap.
    always_comb begin
        req_misalign_d = 1'b0;
    end
`endif

    // Store data for the first byte (from the request) and for later bytes (from the latched operand).
    always_comb begin
        first_byte_d = sel_byte(WData, req_nbytes_d, 3'd0);
        next_byte_d  = sel_byte(wdata_q, nbytes_q, cnt_q);
    end

    // Final load value: extend the assembled bytes according to operand size and signedness.
    always_comb begin
        load_result_d = rbuf_q;
        case (nbytes_q)
            3'd1:    load_result_d = {{24{signed_q & rbuf_q[7]}},  rbuf_q[7:0]};
            3'd2:    load_result_d = {{16{signed_q & rbuf_q[15]}}, rbuf_q[15:0]};
            default: load_result_d = rbuf_q;
        endcase
    end

    // Access sequencer: all outputs are registered so MemEnable rises cleanly for every byte
    // and address/data/direction stay stable for the whole ACCESS cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            nbytes_q   <= 3'd1;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            rdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= 8'd0;
        end else begin
            // Completion and fault flags are single-cycle pulses.
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Req) begin
                        write_q  <= Write;
                        signed_q <= Signed;
                        wdata_q  <= WData;
                        nbytes_q <= req_nbytes_d;
                        cnt_q    <= 3'd0;
                        rbuf_q   <= 32'd0;
                        if (req_misalign_d) begin
                            // Rejected: no memory cycle, report fault together with Done.
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ACCESS;
                            busy_q     <= 1'b1;
                            mem_en_q   <= 1'b1;
                            mem_rw_q   <= Write;
                            mem_addr_q <= Addr;
                            mem_dout_q <= Write ? first_byte_d : 8'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // The memory output is valid by the edge that closes the enable window.
                    if (!write_q)
                        rbuf_q <= {rbuf_q[23:0], MemDataIn};
                    cnt_q      <= cnt_q + 3'd1;
                    state_q    <= ST_GAP;
                    mem_en_q   <= 1'b0;
                    mem_rw_q   <= 1'b0;
                    mem_dout_q <= 8'd0;
                end
                ST_GAP: begin
                    if (cnt_q == nbytes_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (!write_q)
                            rdata_q <= load_result_d;
                    end else begin
                        // Next byte at the following address, modulo the memory size.
                        state_q    <= ST_ACCESS;
                        mem_en_q   <= 1'b1;
                        mem_rw_q   <= write_q;
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);
                        mem_dout_q <= write_q ? next_byte_d : 8'd0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign RData        = rdata_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign MisalignErr  = misalign_q;
    assign MemEnable    = mem_en_q;
    assign MemReadWrite = mem_rw_q;
    assign MemAddress   = mem_addr_q;
    assign MemDataOut   = mem_dout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a 1 KiB byte-memory model and an expected-RData scoreboard.
// Directed sequence: reset, loads/stores of every size, address wrap, held Req, reset mid-store.
// Define MEM_ACCESS_MISALIGN_CHECK_EN for both files to exercise the alignment-fault path.
`timescale 1ns/1ps

module tb_mem_access_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              Reset, Req, Write, Signed;
    logic [1:0]        Size;
    logic [ADDR_W-1:0] Addr;
    logic [31:0]       WData;
    logic [31:0]       RData;
    logic              Busy, Done, MisalignErr, MemEnable, MemReadWrite;
    logic [ADDR_W-1:0] MemAddress;
    logic [7:0]        MemDataOut, MemDataIn;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .Clk(clk), .Reset(Reset), .Req(Req), .Write(Write), .Size(Size),
        .Signed(Signed), .Addr(Addr), .WData(WData), .RData(RData),
        .Busy(Busy), .Done(Done), .MisalignErr(MisalignErr),
        .MemEnable(MemEnable), .MemReadWrite(MemReadWrite),
        .MemAddress(MemAddress), .MemDataOut(MemDataOut), .MemDataIn(MemDataIn)
    );

    // Memory model: asynchronous read, write on the clock while enabled for write.
    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    assign MemDataIn = mem[MemAddress];
    always @(posedge clk) begin
        if (MemEnable && MemReadWrite)
            mem[MemAddress] <= MemDataOut;
    end

    int en_rises = 0;
    always @(posedge MemEnable) en_rises++;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q [$];
    logic [31:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic misaligned_ref(input logic [1:0] sz, input logic [9:0] a);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        if (sz == 2'b01) return a[0];
        if (sz[1])       return (a[1:0] != 2'b00);
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [9:0] a);
        int          n;
        logic [31:0] v;
        logic [9:0]  p;
        n = nbytes_of(sz);
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            p = a + 10'(k);
            v = {v[23:0], ref_mem[p]};
        end
        if (n == 1) v = {{24{sg & v[7]}}, v[7:0]};
        if (n == 2) v = {{16{sg & v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [9:0] a, input logic [31:0] wd);
        int         n;
        logic [9:0] p;
        n = nbytes_of(sz);
        for (int k = 0; k < n; k++) begin
            p = a + 10'(k);
            ref_mem[p] = wd[8*(n-1-k) +: 8];
        end
    endtask

    // One complete access from IDLE; returns with the DUT back in IDLE.
    task automatic do_access(input string tag, input logic wr, input logic [1:0] sz,
                             input logic sg, input logic [9:0] a, input logic [31:0] wd);
        int   n, cyc, exp_cyc, rises0;
        logic mis;
        n   = nbytes_of(sz);
        mis = misaligned_ref(sz, a);
        if (!wr && !mis) exp_rdata = ref_load(sz, sg, a);
        if (wr && !mis)  ref_store(sz, a, wd);
        sb_q.push_back(exp_rdata);
        exp_cyc = mis ? 1 : 2*n + 1;
        rises0  = en_rises;
        Req = 1'b1; Write = wr; Size = sz; Signed = sg; Addr = a; WData = wd;
        tick;
        Req = 1'b0; Write = 1'b0; WData = 32'd0;
        cyc = 1;
        while (!Done && cyc < 40) begin
            tick;
            cyc++;
        end
        check({tag, "/cycles"},   32'(cyc), 32'(exp_cyc));
        check({tag, "/misalign"}, 32'(MisalignErr), 32'(mis));
        check({tag, "/rdata"},    RData, sb_q.pop_front());
        check({tag, "/enables"},  32'(en_rises - rises0), 32'(mis ? 0 : n));
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:1] exp_busy;
        logic [8:1] exp_done;
        int         dcnt;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = (i < 10) ? 8'h99 : 8'h00;
            ref_mem[i] = (i < 10) ? 8'h99 : 8'h00;
        end
        exp_rdata = 32'd0;
        Reset = 1'b1; Req = 1'b1; Write = 1'b1; Size = 2'b10; Signed = 1'b0;
        Addr = '0; WData = 32'hFFFF_FFFF;

        // Reset wins over a pending Req.
        repeat (3) tick;
        check("rst/rdata",    RData, 32'd0);
        check("rst/busy",     32'(Busy), 32'd0);
        check("rst/done",     32'(Done), 32'd0);
        check("rst/misalign", 32'(MisalignErr), 32'd0);
        check("rst/en",       32'(MemEnable), 32'd0);
        check("rst/rw",       32'(MemReadWrite), 32'd0);
        check("rst/addr",     32'(MemAddress), 32'd0);
        check("rst/dout",     32'(MemDataOut), 32'd0);
        Req = 1'b0; Write = 1'b0; WData = 32'd0;
        Reset = 1'b0;
        tick;

        do_access("wload0", 1'b0, 2'b10, 1'b0, 10'd0, 32'd0);
        check("wload0/value", RData, 32'h9999_9999);
        do_access("bload3s", 1'b0, 2'b00, 1'b1, 10'd3, 32'd0);
        check("bload3s/value", RData, 32'hFFFF_FF99);
        do_access("bload3u", 1'b0, 2'b00, 1'b0, 10'd3, 32'd0);
        check("bload3u/value", RData, 32'h0000_0099);

        do_access("wstore8", 1'b1, 2'b10, 1'b0, 10'd8, 32'h1234_5678);
        do_access("wload8", 1'b0, 2'b10, 1'b0, 10'd8, 32'd0);
        check("wload8/value", RData, 32'h1234_5678);
        check("mem8",  32'(mem[8]),  32'h12);
        check("mem9",  32'(mem[9]),  32'h34);
        check("mem10", 32'(mem[10]), 32'h56);
        check("mem11", 32'(mem[11]), 32'h78);

        do_access("hload8s", 1'b0, 2'b01, 1'b1, 10'd8, 32'd0);
        check("hload8s/value", RData, 32'h0000_1234);
        do_access("hstore12", 1'b1, 2'b01, 1'b0, 10'd12, 32'h0000_80FE);
        do_access("hload12s", 1'b0, 2'b01, 1'b1, 10'd12, 32'd0);
        check("hload12s/value", RData, 32'hFFFF_80FE);
        do_access("rsvload8", 1'b0, 2'b11, 1'b0, 10'd8, 32'd0);

        do_access("hstore1023", 1'b1, 2'b01, 1'b0, 10'd1023, 32'h0000_ABCD);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        check("mem1023_untouched", 32'(mem[1023]), 32'h00);
        check("mem0_untouched",    32'(mem[0]),    32'h99);
`else
        check("mem1023", 32'(mem[1023]), 32'hAB);
        check("mem0",    32'(mem[0]),    32'hCD);
        do_access("hload1023", 1'b0, 2'b01, 1'b0, 10'd1023, 32'd0);
        check("hload1023/value", RData, 32'h0000_ABCD);
`endif

        // Req held high: second acceptance only from IDLE after Done.
        exp_busy = 8'b0011_0011;
        exp_done = 8'b0100_0100;
        Req = 1'b1; Write = 1'b0; Size = 2'b00; Signed = 1'b0; Addr = 10'd3;
        for (int i = 1; i <= 8; i++) begin
            tick;
            check($sformatf("heldreq/busy%0d", i), 32'(Busy), 32'(exp_busy[i]));
            check($sformatf("heldreq/done%0d", i), 32'(Done), 32'(exp_done[i]));
        end
        Req = 1'b0;
        exp_rdata = 32'h0000_0099;
        check("heldreq/rdata", RData, exp_rdata);

        // Reset in the GAP after byte 1 of a word store.
        Req = 1'b1; Write = 1'b1; Size = 2'b10; Addr = 10'd20; WData = 32'hA1B2_C3D4;
        tick;
        Req = 1'b0; Write = 1'b0;
        repeat (3) tick;
        check("abort/busy_in_gap", 32'(Busy), 32'd1);
        check("abort/en_in_gap",   32'(MemEnable), 32'd0);
        Reset = 1'b1;
        tick;
        check("abort/rdata", RData, 32'd0);
        check("abort/busy",  32'(Busy), 32'd0);
        check("abort/done",  32'(Done), 32'd0);
        check("abort/en",    32'(MemEnable), 32'd0);
        check("abort/rw",    32'(MemReadWrite), 32'd0);
        check("abort/addr",  32'(MemAddress), 32'd0);
        check("abort/dout",  32'(MemDataOut), 32'd0);
        Reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            dcnt += int'(Done);
        end
        check("abort/no_done", 32'(dcnt), 32'd0);
        check("abort/mem20", 32'(mem[20]), 32'hA1);
        check("abort/mem21", 32'(mem[21]), 32'hB2);
        check("abort/mem22", 32'(mem[22]), 32'h00);
        check("abort/mem23", 32'(mem[23]), 32'h00);
        ref_mem[20] = 8'hA1;
        ref_mem[21] = 8'hB2;
        exp_rdata   = 32'd0;
        do_access("postrst", 1'b0, 2'b10, 1'b0, 10'd20, 32'd0);
        check("postrst/value", RData, 32'hA1B2_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: byte-address width of the attached 8-bit data memory (1024 bytes).
REQ-002 SHALL have port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port Req, input, 1: access request from the pipeline MEM stage.
REQ-005 SHALL have port Write, input, 1: 1 = store, 0 = load; sampled with Req.
REQ-006 SHALL have port Size, input, 2: 00 byte, 01 half, 10 word, 11 reserved and treated as word.
REQ-007 SHALL have port Signed, input, 1: 1 = sign-extend loaded byte/half, 0 = zero-extend.
REQ-008 SHALL have port Addr, input, ADDR_W: start byte address.
REQ-009 SHALL have port WData, input, 32: store data, right-justified for byte/half.
REQ-010 SHALL have port RData, output, 32: load result.
REQ-011 SHALL have port Busy, output, 1: access in progress.
REQ-012 SHALL have port Done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port MisalignErr, output, 1: one-cycle alignment-fault pulse.
REQ-014 SHALL have port MemEnable, output, 1: drives the memory Enable.
REQ-015 SHALL have port MemReadWrite, output, 1: drives the memory ReadWrite (0 read, 1 write).
REQ-016 SHALL have port MemAddress, output, ADDR_W: drives the memory Address.
REQ-017 SHALL have port MemDataOut, output, 8: drives the memory DataIn.
REQ-018 SHALL have port MemDataIn, input, 8: receives the memory DataOut.

Function
REQ-019 SHALL implement the FSM IDLE -> ACCESS -> GAP -> (ACCESS for the next byte | DONE) -> IDLE.
REQ-020 SHALL accept Req only in IDLE, latching Write, Size, Signed, Addr and WData; Req in any other state SHALL be ignored.
REQ-021 SHALL transfer N bytes per access (N = 1, 2, 4 for byte, half, word); byte k SHALL use address Addr+k modulo 2^ADDR_W.
REQ-022 SHALL hold MemEnable=1 in ACCESS and MemEnable=0 in every other state, so every byte access starts with an Enable rising edge.
REQ-023 SHALL keep MemAddress, MemReadWrite and MemDataOut stable throughout ACCESS.
REQ-024 SHALL, for loads, capture MemDataIn on the clock edge that ends ACCESS.
REQ-025 SHALL order bytes big-endian: byte k at Addr+k is the k-th most significant byte of the operand (word k=0 -> WData[31:24]; half k=0 -> WData[15:8]).
REQ-026 SHALL set RData as follows: word {b0,b1,b2,b3}; half = extend({b0,b1}) to 32 bits; byte = extend(b0) to 32 bits.
REQ-027 SHALL update RData only in DONE of a load and hold it until the next completed load; stores SHALL leave RData unchanged.
REQ-028 SHALL assert Busy in ACCESS and GAP only.
REQ-029 SHALL pulse Done for one cycle in DONE, 2N+1 cycles after the accepting edge.
REQ-030 SHALL drive MemReadWrite=0 and MemDataOut=0 whenever not in ACCESS.

Reset
REQ-031 SHALL, while Reset is high, force state IDLE, RData=0, Busy=0, Done=0, MisalignErr=0, MemEnable=0, MemReadWrite=0, MemAddress=0 and MemDataOut=0; Reset SHALL take priority over Req.
REQ-032 SHALL, on reset during an access, abort it with no Done pulse; store bytes already written SHALL remain in memory.

Configuration
REQ-033 SHALL, with macro MEM_ACCESS_MISALIGN_CHECK_EN defined, reject a half access with Addr[0]=1 and a word access with Addr[1:0]!=0: no memory access, state goes directly to DONE, and Done and MisalignErr pulse together in the cycle after acceptance, with RData unchanged.
REQ-034 SHALL, without MEM_ACCESS_MISALIGN_CHECK_EN, tie MisalignErr to 0 and perform every access at any alignment, wrapping per REQ-021.

Verification
REQ-035 SHALL cover: memory bytes 0-9 = 0x99, word load at Addr 0 -> RData=0x99999999, Done 9 cycles after acceptance, exactly 4 MemEnable rising edges.
REQ-036 SHALL cover: byte load at Addr 3, Signed=1 -> RData=0xFFFFFF99; Signed=0 -> RData=0x00000099.
REQ-037 SHALL cover: word store 0x12345678 at Addr 8, then word load at Addr 8 -> memory[8..11]=12,34,56,78 and RData=0x12345678.
REQ-038 SHALL cover: with the macro off, half store 0xABCD at Addr 1023 -> memory[1023]=0xAB and memory[0]=0xCD; with the macro on, the same request -> MisalignErr=1 and Done=1 in the same cycle, and MemEnable never rises.
REQ-039 SHALL cover: Reset asserted during GAP after byte 1 of a word store -> next cycle IDLE with all outputs at reset values, no Done pulse, and memory holding only bytes 0-1.
REQ-040 SHALL cover: Req held high throughout an access -> the second request is accepted only in IDLE after Done, never while Busy=1.
